// File: rtl/i2c_rtc_slave.sv
// I2C slave front end for an RTC-style register file: 7-bit addressing,
// pointer byte followed by auto-incrementing writes, or reads from the
// current pointer. Everything runs on sys_clk; SCL/SDA are oversampled.
`timescale 1ns/1ps
module i2c_rtc_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h68
) (
  input  logic       i_sys_clk,
  input  logic       i_rst,
  input  logic       i_scl_in,
  input  logic       i_sda_in,
  output logic       o_sda_oe,
  output logic [7:0] o_reg_addr,
  output logic [7:0] o_reg_wdata,
  output logic       o_reg_write,
  input  logic [7:0] i_reg_rdata,
  output logic       o_busy
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_ADDR      = 4'd1;
  localparam logic [3:0] S_ADDR_ACK  = 4'd2;
  localparam logic [3:0] S_PTR       = 4'd3;
  localparam logic [3:0] S_PTR_ACK   = 4'd4;
  localparam logic [3:0] S_WDATA     = 4'd5;
  localparam logic [3:0] S_WDATA_ACK = 4'd6;
  localparam logic [3:0] S_RDATA     = 4'd7;
  localparam logic [3:0] S_RDATA_ACK = 4'd8;
  localparam logic [3:0] S_WAIT_STOP = 4'd9;

  logic       r_scl_s1, r_scl_s2, r_scl_h;
  logic       r_sda_s1, r_sda_s2, r_sda_h;
  logic [3:0] r_state;
  logic [3:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic       r_rw;
  logic       r_sda_oe;
  logic       r_busy;
  logic [7:0] r_reg_addr;
  logic [7:0] r_reg_wdata;
  logic       r_reg_write;

  logic       w_scl_rise, w_scl_fall, w_start, w_stop, w_addr_hit;
  logic [7:0] w_shift_in;

  assign w_scl_rise = r_scl_s2 & ~r_scl_h;
  assign w_scl_fall = ~r_scl_s2 & r_scl_h;
  assign w_start    = r_scl_s2 & r_scl_h & r_sda_h & ~r_sda_s2;
  assign w_stop     = r_scl_s2 & r_scl_h & ~r_sda_h & r_sda_s2;
  assign w_shift_in = {r_shift[6:0], r_sda_s2};
  // General call (address 0) never matches, even if SLAVE_ADDR were set to 0.
  assign w_addr_hit = (r_shift[7:1] == SLAVE_ADDR) && (r_shift[7:1] != 7'h00);

  assign o_sda_oe    = r_sda_oe;
  assign o_busy      = r_busy;
  assign o_reg_addr  = r_reg_addr;
  assign o_reg_wdata = r_reg_wdata;
  assign o_reg_write = r_reg_write;

  // Two-flop synchronizers plus history flop; preset high so reset release looks like an idle bus.
  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_scl_h  <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
      r_sda_h  <= 1'b1;
    end else begin
      r_scl_s1 <= i_scl_in;
      r_scl_s2 <= r_scl_s1;
      r_scl_h  <= r_scl_s2;
      r_sda_s1 <= i_sda_in;
      r_sda_s2 <= r_sda_s1;
      r_sda_h  <= r_sda_s2;
    end
  end

  // Protocol FSM: START/STOP override bit handling; sample on SCL rise, drive on SCL fall.
  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= 4'd0;
      r_shift     <= 8'h00;
      r_rw        <= 1'b0;
      r_sda_oe    <= 1'b0;
      r_busy      <= 1'b0;
      r_reg_addr  <= 8'h00;
      r_reg_wdata <= 8'h00;
      r_reg_write <= 1'b0;
    end else begin
      r_reg_write <= 1'b0;
      if (w_start) begin
        r_state   <= S_ADDR;
        r_bit_cnt <= 4'd0;
        r_shift   <= 8'h00;
        r_sda_oe  <= 1'b0;
        r_busy    <= 1'b0;
      end else if (w_stop) begin
        r_state   <= S_IDLE;
        r_bit_cnt <= 4'd0;
        r_sda_oe  <= 1'b0;
        r_busy    <= 1'b0;
      end else begin
        case (r_state)
          S_ADDR, S_PTR, S_WDATA: begin
            if (w_scl_rise && (r_bit_cnt < 4'd8)) begin
              r_shift   <= w_shift_in;
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if ((r_state == S_WDATA) && (r_bit_cnt == 4'd7)) begin
                r_reg_wdata <= w_shift_in;
                r_reg_write <= 1'b1;
              end
            end else if (w_scl_fall && (r_bit_cnt == 4'd8)) begin
              r_bit_cnt <= 4'd0;
              if (r_state == S_ADDR) begin
                if (w_addr_hit) begin
                  r_sda_oe <= 1'b1;
                  r_busy   <= 1'b1;
                  r_rw     <= r_shift[0];
                  r_state  <= S_ADDR_ACK;
                end else begin
                  r_state <= S_WAIT_STOP;
                end
              end else if (r_state == S_PTR) begin
                r_reg_addr <= r_shift;
                r_sda_oe   <= 1'b1;
                r_state    <= S_PTR_ACK;
              end else begin
                r_sda_oe <= 1'b1;
                r_state  <= S_WDATA_ACK;
              end
            end
          end
          S_ADDR_ACK: begin
            if (w_scl_fall) begin
              r_bit_cnt <= 4'd0;
              if (r_rw) begin
                r_shift  <= i_reg_rdata;
                r_sda_oe <= ~i_reg_rdata[7];
                r_state  <= S_RDATA;
              end else begin
                r_sda_oe <= 1'b0;
                r_state  <= S_PTR;
              end
            end
          end
          S_PTR_ACK: begin
            if (w_scl_fall) begin
              r_sda_oe <= 1'b0;
              r_state  <= S_WDATA;
            end
          end
          S_WDATA_ACK: begin
            if (w_scl_fall) begin
              r_sda_oe   <= 1'b0;
              r_reg_addr <= r_reg_addr + 8'd1;
              r_state    <= S_WDATA;
            end
          end
          S_RDATA: begin
            if (w_scl_rise && (r_bit_cnt < 4'd8)) begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall) begin
              if (r_bit_cnt == 4'd8) begin
                r_sda_oe  <= 1'b0;
                r_bit_cnt <= 4'd0;
                r_state   <= S_RDATA_ACK;
              end else begin
                r_shift  <= {r_shift[6:0], 1'b0};
                r_sda_oe <= ~r_shift[6];
              end
            end
          end
          S_RDATA_ACK: begin
            if (w_scl_rise) begin
              if (!r_sda_s2) begin
                // Bump the pointer early so reg_rdata has settled by the 9th fall.
                r_reg_addr <= r_reg_addr + 8'd1;
              end else begin
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b0;
                r_state  <= S_WAIT_STOP;
              end
            end else if (w_scl_fall) begin
              r_shift   <= i_reg_rdata;
              r_sda_oe  <= ~i_reg_rdata[7];
              r_bit_cnt <= 4'd0;
              r_state   <= S_RDATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_rtc_slave.sv
// Directed bench for i2c_rtc_slave: bit-banged I2C master, register-file
// model returning addr+0x10, write log and SDA-drive monitor.
`timescale 1ns/1ps
module tb_i2c_rtc_slave;

  localparam int Q = 8;  // sys_clk cycles per quarter SCL bit

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_oe;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_write, busy;
  logic       bus_sda;

  int checks = 0;
  int errors = 0;

  // Write log and drive monitor
  int         wr_cnt = 0;
  int         oe_cnt = 0;
  logic [7:0] wr_addr_log [64];
  logic [7:0] wr_data_log [64];

  always #5 clk = ~clk;

  assign bus_sda   = m_sda & ~sda_oe;
  assign reg_rdata = reg_addr + 8'h10;

  i2c_rtc_slave #(.SLAVE_ADDR(7'h68)) dut (
    .i_sys_clk  (clk),
    .i_rst      (rst),
    .i_scl_in   (m_scl),
    .i_sda_in   (bus_sda),
    .o_sda_oe   (sda_oe),
    .o_reg_addr (reg_addr),
    .o_reg_wdata(reg_wdata),
    .o_reg_write(reg_write),
    .i_reg_rdata(reg_rdata),
    .o_busy     (busy)
  );

  always @(posedge clk) begin
    if (reg_write) begin
      if (wr_cnt < 64) begin
        wr_addr_log[wr_cnt] = reg_addr;
        wr_data_log[wr_cnt] = reg_wdata;
      end
      wr_cnt = wr_cnt + 1;
    end
    if (sda_oe) oe_cnt = oe_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic m_start();
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic m_stop();
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b1; tick(Q);
  endtask

  task automatic m_bit(input logic b, output logic s);
    m_sda = b;    tick(Q);
    m_scl = 1'b1; tick(Q);
    s = bus_sda;  tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic m_write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) m_bit(d[i], s);
    m_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic m_read_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      m_bit(1'b1, s);
      d[i] = s;
    end
    m_bit(~mack, s);
  endtask

  typedef struct {
    logic [7:0] ptr;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [7:0] a0;
    logic [7:0] a1;
    logic [7:0] fin;
  } wvec_t;

  wvec_t vecs [3];

  initial begin
    logic       ack, s;
    logic [7:0] rd;
    int         wr0, oe0;

    vecs[0] = '{ptr: 8'h05, d0: 8'h3A, d1: 8'h7C, a0: 8'h05, a1: 8'h06, fin: 8'h07};
    vecs[1] = '{ptr: 8'hFF, d0: 8'h11, d1: 8'h22, a0: 8'hFF, a1: 8'h00, fin: 8'h01};
    vecs[2] = '{ptr: 8'h80, d0: 8'h00, d1: 8'hFF, a0: 8'h80, a1: 8'h81, fin: 8'h82};

    // Reset state
    tick(3);
    chk("rst_sda_oe", 32'(sda_oe), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_reg_addr", 32'(reg_addr), 32'h00);
    chk("rst_reg_wdata", 32'(reg_wdata), 32'h00);
    chk("rst_reg_write", 32'(reg_write), 32'h0);
    rst = 1'b0;
    tick(6);
    chk("post_rst_busy", 32'(busy), 32'h0);
    chk("post_rst_oe", 32'(oe_cnt), 32'h0);

    // Pointer write followed by two data bytes
    for (int v = 0; v < 3; v++) begin
      wr0 = wr_cnt;
      m_start();
      m_write_byte(8'hD0, ack);       chk($sformatf("v%0d_ack_addr", v), 32'(ack), 32'h1);
      chk($sformatf("v%0d_busy", v), 32'(busy), 32'h1);
      m_write_byte(vecs[v].ptr, ack); chk($sformatf("v%0d_ack_ptr", v), 32'(ack), 32'h1);
      m_write_byte(vecs[v].d0, ack);  chk($sformatf("v%0d_ack_d0", v), 32'(ack), 32'h1);
      m_write_byte(vecs[v].d1, ack);  chk($sformatf("v%0d_ack_d1", v), 32'(ack), 32'h1);
      m_stop();
      tick(4);
      chk($sformatf("v%0d_wr_count", v), 32'(wr_cnt - wr0), 32'd2);
      if (wr_cnt - wr0 == 2 && wr_cnt <= 64) begin
        chk($sformatf("v%0d_wa0", v), 32'(wr_addr_log[wr0]), 32'(vecs[v].a0));
        chk($sformatf("v%0d_wd0", v), 32'(wr_data_log[wr0]), 32'(vecs[v].d0));
        chk($sformatf("v%0d_wa1", v), 32'(wr_addr_log[wr0 + 1]), 32'(vecs[v].a1));
        chk($sformatf("v%0d_wd1", v), 32'(wr_data_log[wr0 + 1]), 32'(vecs[v].d1));
      end
      chk($sformatf("v%0d_final_addr", v), 32'(reg_addr), 32'(vecs[v].fin));
      chk($sformatf("v%0d_busy_end", v), 32'(busy), 32'h0);
    end

    // Random read: pointer 0x02, repeated START, two bytes (ACK then NACK)
    m_start();
    m_write_byte(8'hD0, ack); chk("rd_ack_waddr", 32'(ack), 32'h1);
    m_write_byte(8'h02, ack); chk("rd_ack_ptr", 32'(ack), 32'h1);
    m_start();
    m_write_byte(8'hD1, ack); chk("rd_ack_raddr", 32'(ack), 32'h1);
    m_read_byte(1'b1, rd);    chk("rd_byte0", 32'(rd), 32'h12);
    m_read_byte(1'b0, rd);    chk("rd_byte1", 32'(rd), 32'h13);
    chk("rd_busy_after_nack", 32'(busy), 32'h0);
    chk("rd_oe_after_nack", 32'(sda_oe), 32'h0);
    m_stop();
    tick(4);
    chk("rd_final_addr", 32'(reg_addr), 32'h03);

    // Address mismatch and general call: never drive SDA, never write
    for (int k = 0; k < 2; k++) begin
      wr0 = wr_cnt;
      oe0 = oe_cnt;
      m_start();
      m_write_byte((k == 0) ? 8'hA0 : 8'h00, ack);
      chk($sformatf("mm%0d_nack", k), 32'(ack), 32'h0);
      m_write_byte(8'h00, ack);
      chk($sformatf("mm%0d_nack2", k), 32'(ack), 32'h0);
      m_stop();
      tick(4);
      chk($sformatf("mm%0d_oe_cycles", k), 32'(oe_cnt - oe0), 32'd0);
      chk($sformatf("mm%0d_writes", k), 32'(wr_cnt - wr0), 32'd0);
      chk($sformatf("mm%0d_busy", k), 32'(busy), 32'h0);
    end

    // Abort: STOP after 4 bits of a data byte
    wr0 = wr_cnt;
    m_start();
    m_write_byte(8'hD0, ack); chk("ab_ack_addr", 32'(ack), 32'h1);
    m_write_byte(8'h40, ack); chk("ab_ack_ptr", 32'(ack), 32'h1);
    m_bit(1'b1, s); m_bit(1'b0, s); m_bit(1'b1, s); m_bit(1'b1, s);
    m_stop();
    tick(4);
    chk("ab_writes", 32'(wr_cnt - wr0), 32'd0);
    chk("ab_reg_addr", 32'(reg_addr), 32'h40);
    chk("ab_busy", 32'(busy), 32'h0);
    chk("ab_oe", 32'(sda_oe), 32'h0);

    // Reset while driving bit 7 (=0) of 0x50, then read from pointer 0x00
    m_start();
    m_write_byte(8'hD1, ack); chk("rr_ack", 32'(ack), 32'h1);
    chk("rr_driving_zero", 32'(sda_oe), 32'h1);
    rst = 1'b1;
    #1;
    chk("rr_oe_async", 32'(sda_oe), 32'h0);
    tick(2);
    rst = 1'b0;
    tick(4);
    chk("rr_addr_cleared", 32'(reg_addr), 32'h00);
    chk("rr_busy", 32'(busy), 32'h0);
    m_start();
    m_write_byte(8'hD1, ack); chk("rr_ack2", 32'(ack), 32'h1);
    m_read_byte(1'b0, rd);    chk("rr_byte", 32'(rd), 32'h10);
    m_stop();
    tick(4);
    chk("rr_final_addr", 32'(reg_addr), 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_rtc_slave.md
I2C_RTC_SLAVE -- requirements
Module: i2c_rtc_slave

Interface
REQ-001 Parameter SLAVE_ADDR, default 7'h68, 7-bit I2C address this block responds to.
REQ-002 sys_clk  input  1  system clock (50 MHz nominal); the only clock in the block.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 scl_in  input  1  raw I2C SCL from pad; asynchronous to sys_clk.
REQ-005 sda_in  input  1  raw I2C SDA from pad; asynchronous to sys_clk.
REQ-006 sda_oe  output  1  1 = pull SDA low, 0 = release (pad is open-drain; top level forms sda = sda_oe ? 0 : z).
REQ-007 reg_addr  output  8  register pointer presented to the external register file.
REQ-008 reg_wdata  output  8  write data, valid while reg_write=1.
REQ-009 reg_write  output  1  single-cycle write strobe.
REQ-010 reg_rdata  input  8  read data for reg_addr; combinational from the register file, valid 1 cycle after reg_addr changes.
REQ-011 busy  output  1  high from address match until STOP, repeated START or NACK-terminated read.

Function
REQ-012 scl_in and sda_in SHALL each pass a 2-flop synchronizer plus one history flop; all detection uses synchronized values; input-to-detect latency 3 sys_clk.
REQ-013 START = SDA falling while SCL high; STOP = SDA rising while SCL high; both SHALL be recognized in every state and take priority over bit processing in the same cycle.
REQ-014 States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
REQ-015 START (including repeated START) -> ADDR, bit counter cleared, sda_oe=0; STOP -> IDLE, sda_oe=0, busy=0.
REQ-016 Bits SHALL be sampled on synchronized SCL rising edge, MSB first; SDA drive changes only on synchronized SCL falling edge.
REQ-017 ADDR: after 8 bits, if addr[7:1]==SLAVE_ADDR -> ADDR_ACK with sda_oe=1 from the 8th falling edge to the 9th falling edge; mismatch -> WAIT_STOP, sda_oe never asserted.
REQ-018 Address R/W=0: after ACK -> PTR; the next byte is loaded into reg_addr and ACKed (PTR_ACK), then -> WDATA.
REQ-019 WDATA: each received byte is ACKed; at the 8th rising edge reg_wdata=byte and reg_write pulses exactly 1 cycle with reg_addr unchanged; reg_addr then increments at the 9th falling edge.
REQ-020 Address R/W=1: at the ACK's 9th falling edge the shift register loads reg_rdata and bit 7 is driven (sda_oe = ~bit); -> RDATA.
REQ-021 RDATA: 8 bits driven; at the 8th falling edge sda_oe=0 (release) -> RDATA_ACK.
REQ-022 RDATA_ACK: SDA sampled low at 9th rising edge (master ACK) -> reg_addr increments, next byte loaded from reg_rdata at the 9th falling edge -> RDATA; SDA high (NACK) -> WAIT_STOP, busy=0, sda_oe=0.
REQ-023 reg_addr SHALL wrap 8'hFF -> 8'h00 on increment in both read and write.
REQ-024 reg_addr SHALL persist across transactions (a read without a pointer write continues from the last pointer).
REQ-025 START or STOP mid-byte SHALL abort the byte: no reg_write, partial data discarded, reg_addr unchanged.
REQ-026 General-call (address 0) is not supported: treated as a mismatch.

Reset
REQ-027 On rst: state=IDLE, sda_oe=0, reg_write=0, reg_wdata=8'h00, reg_addr=8'h00, busy=0, bit counter and shift register cleared; synchronizer flops preset to 1 (bus idle), so reset release does not produce a false START/STOP.
REQ-028 rst asserted mid-transaction SHALL release SDA within the same cycle (asynchronous); the block resumes only on the next START.

Verification
REQ-029 Write: START, 0xD0, 0x05, 0x3A, 0x7C, STOP -> ACK on all 4 bytes; reg_write pulses twice: (addr 0x05, data 0x3A), (0x06, 0x7C); final reg_addr=0x07.
REQ-030 Random read: START, 0xD0, 0x02, repeated START, 0xD1, master ACK, master NACK, STOP; model register file returns addr+0x10 -> SDA bytes 0x12, 0x13; busy=0 after NACK.
REQ-031 Address mismatch: START, 0xA0, 0x00, STOP -> sda_oe stays 0 throughout; no reg_write.
REQ-032 Wrap: pointer 0xFF, write 0x11, 0x22 -> writes at 0xFF then 0x00.
REQ-033 Abort: STOP after 4 bits of a data byte -> no reg_write, state IDLE, reg_addr unchanged.
REQ-034 Reset mid-read while driving a 0 bit -> sda_oe=0 within 1 cycle; a subsequent 0xD1 read returns data from reg_addr=0x00.
